// File: rtl/lsu_pkg.sv
// Shared FSM encodings, size codes and bus-geometry helpers for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StReq0 = 3'd1;
    localparam logic [2:0] StRw0  = 3'd2;
    localparam logic [2:0] StReq1 = 3'd3;
    localparam logic [2:0] StRw1  = 3'd4;
    localparam logic [2:0] StResp = 3'd5;

    localparam logic [1:0] SzByte   = 2'd0;
    localparam logic [1:0] SzHalf   = 2'd1;
    localparam logic [1:0] SzWord   = 2'd2;
    localparam logic [1:0] SzDouble = 2'd3;

    function automatic int unsigned lsu_nb(input int unsigned data_w);
        return data_w / 8;
    endfunction

    function automatic int unsigned lsu_log2_nb(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: beat strobes, store data rotation, load shift and extend.
module lsu_lane_align #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [2:0]          off_i,
    input  logic [1:0]          size_i,
    input  logic                unsigned_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W-1:0]   beat0_i,
    input  logic [DATA_W-1:0]   beat1_i,
    output logic [DATA_W/8-1:0] strb0_o,
    output logic [DATA_W/8-1:0] strb1_o,
    output logic [DATA_W-1:0]   wdata0_o,
    output logic [DATA_W-1:0]   wdata1_o,
    output logic [DATA_W-1:0]   rdata_o
);

    localparam int unsigned NB = DATA_W / 8;

    logic [2*NB-1:0]     mask_w;
    logic [2*NB-1:0]     strb_w;
    logic [2*DATA_W-1:0] wrot;
    logic [DATA_W-1:0]   rsh;
    logic                sign;
    int                  nbits;

    always_comb begin
        mask_w = '0;
        for (int i = 0; i < 2 * NB; i++) begin
            mask_w[i] = (i < (1 << size_i));
        end
        strb_w   = mask_w << off_i;
        strb0_o  = strb_w[NB-1:0];
        strb1_o  = strb_w[2*NB-1:NB];

        // Upper half starts at zero and off*8 < DATA_W, so the rotate never wraps.
        wrot     = {{DATA_W{1'b0}}, wdata_i} << {off_i, 3'b000};
        wdata0_o = wrot[DATA_W-1:0];
        wdata1_o = wrot[2*DATA_W-1:DATA_W];

        rsh   = DATA_W'({beat1_i, beat0_i} >> {off_i, 3'b000});
        nbits = 8 << size_i;
        if (nbits > int'(DATA_W)) begin
            nbits = int'(DATA_W);
        end
        sign = 1'b0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            if (i == nbits - 1) begin
                sign = rsh[i];
            end
        end
        rdata_o = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            rdata_o[i] = (i < nbits) ? rsh[i] : (sign & ~unsigned_i);
        end
    end

endmodule

// File: rtl/lsu_mc_param.sv
// Multi-cycle load/store unit: splits bus-word-crossing accesses into two beats and keeps perf counts.
module lsu_mc_param
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter bit          MISALIGN_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [31:0]         req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic [31:0]         Address,
    output logic                MemWrite,
    output logic                MemRead,
    output logic [DATA_W-1:0]   Write_data,
    output logic [DATA_W/8-1:0] Write_strb,
    input  logic                Mem_Req_Ready,
    input  logic [DATA_W-1:0]   Read_data,
    input  logic                Read_data_Valid,
    output logic                Read_data_Ready,
    output logic [31:0]         perf_ld_cycles,
    output logic [31:0]         perf_st_cycles,
    output logic [31:0]         perf_split
);

    localparam int unsigned NB     = lsu_nb(DATA_W);
    localparam int unsigned LOG2NB = lsu_log2_nb(DATA_W);

    logic [2:0]        state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              we_q, we_d;
    logic              uns_q, uns_d;
    logic              split_q, split_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] beat0_q, beat0_d;
    logic [DATA_W-1:0] beat1_q, beat1_d;
    logic [31:0]       perf_ld_q, perf_ld_d;
    logic [31:0]       perf_st_q, perf_st_d;
    logic [31:0]       perf_split_q, perf_split_d;

    logic [2:0]        off_in, off_q;
    logic              split_in, size_bad, err_in;
    logic              in_req, in_rw;
    logic [31:0]       base_addr;
    logic [NB-1:0]     strb0, strb1;
    logic [DATA_W-1:0] wdata0, wdata1, ext_rdata;

    always_comb begin
        off_in   = req_addr[2:0] & 3'(NB - 1);
        split_in = ({1'b0, off_in} + (4'd1 << req_size)) > 4'(NB);
        size_bad = req_size > 2'(LOG2NB);
        err_in   = size_bad | (split_in & !MISALIGN_EN);
        off_q    = addr_q[2:0] & 3'(NB - 1);
        base_addr = addr_q & ~32'(NB - 1);
        in_req   = (state_q == StReq0) || (state_q == StReq1);
        in_rw    = (state_q == StRw0) || (state_q == StRw1);
    end

    lsu_lane_align #(
        .DATA_W (DATA_W)
    ) u_lane_align (
        .off_i      (off_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q),
        .beat0_i    (beat0_q),
        .beat1_i    (split_q ? beat1_q : '0),
        .strb0_o    (strb0),
        .strb1_o    (strb1),
        .wdata0_o   (wdata0),
        .wdata1_o   (wdata1),
        .rdata_o    (ext_rdata)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        we_d         = we_q;
        uns_d        = uns_q;
        split_d      = split_q;
        err_d        = err_q;
        wdata_d      = wdata_q;
        beat0_d      = beat0_q;
        beat1_d      = beat1_q;
        perf_ld_d    = perf_ld_q;
        perf_st_d    = perf_st_q;
        perf_split_d = perf_split_q;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    size_d  = req_size;
                    we_d    = req_we;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    split_d = split_in & ~err_in;
                    err_d   = err_in;
                    state_d = err_in ? StResp : StReq0;
                    if (split_in && !err_in) begin
                        perf_split_d = perf_split_q + 32'd1;
                    end
                end
            end
            StReq0: begin
                if (Mem_Req_Ready) begin
                    state_d = we_q ? (split_q ? StReq1 : StResp) : StRw0;
                end
            end
            StRw0: begin
                if (Read_data_Valid) begin
                    beat0_d = Read_data;
                    state_d = split_q ? StReq1 : StResp;
                end
            end
            StReq1: begin
                if (Mem_Req_Ready) begin
                    state_d = we_q ? StResp : StRw1;
                end
            end
            StRw1: begin
                if (Read_data_Valid) begin
                    beat1_d = Read_data;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if ((in_req || in_rw) && !we_q) begin
            perf_ld_d = perf_ld_q + 32'd1;
        end
        if (in_req && we_q) begin
            perf_st_d = perf_st_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            size_q       <= '0;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            split_q      <= 1'b0;
            err_q        <= 1'b0;
            wdata_q      <= '0;
            beat0_q      <= '0;
            beat1_q      <= '0;
            perf_ld_q    <= '0;
            perf_st_q    <= '0;
            perf_split_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            we_q         <= we_d;
            uns_q        <= uns_d;
            split_q      <= split_d;
            err_q        <= err_d;
            wdata_q      <= wdata_d;
            beat0_q      <= beat0_d;
            beat1_q      <= beat1_d;
            perf_ld_q    <= perf_ld_d;
            perf_st_q    <= perf_st_d;
            perf_split_q <= perf_split_d;
        end
    end

    always_comb begin
        req_ready       = (state_q == StIdle);
        resp_valid      = (state_q == StResp);
        resp_err        = resp_valid & err_q;
        resp_rdata      = (resp_valid && !we_q && !err_q) ? ext_rdata : '0;
        Read_data_Ready = in_rw;
        MemRead         = in_req & ~we_q;
        MemWrite        = in_req & we_q;
        Address         = '0;
        Write_strb      = '0;
        Write_data      = '0;
        if (in_req) begin
            Address    = (state_q == StReq1) ? base_addr + 32'(NB) : base_addr;
            Write_strb = (state_q == StReq1) ? strb1 : strb0;
            if (we_q) begin
                Write_data = (state_q == StReq1) ? wdata1 : wdata0;
            end
        end
        perf_ld_cycles = perf_ld_q;
        perf_st_cycles = perf_st_q;
        perf_split     = perf_split_q;
    end

endmodule

// File: tb/tb_lsu_mc_param.sv
// Directed bench: three LSU instances (32-bit split, 32-bit reject-misaligned, 64-bit) with a zero-wait memory.
module tb_lsu_mc_param;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_we, req_unsigned, resp_ready, Mem_Req_Ready, Read_data_Valid, rv_en;
    logic [1:0]  req_size;
    logic [31:0] req_addr, Read_data;
    logic [63:0] req_wdata;
    logic        m_req_valid, nm_req_valid, w_req_valid;

    logic        m_req_ready, m_resp_valid, m_resp_err, m_MemWrite, m_MemRead, m_Read_data_Ready;
    logic [31:0] m_resp_rdata, m_Address, m_Write_data, m_perf_ld, m_perf_st, m_perf_split;
    logic [3:0]  m_Write_strb;

    logic        nm_req_ready, nm_resp_valid, nm_resp_err, nm_MemWrite, nm_MemRead, nm_Read_data_Ready;
    logic [31:0] nm_resp_rdata, nm_Address, nm_Write_data, nm_perf_ld, nm_perf_st, nm_perf_split;
    logic [3:0]  nm_Write_strb;

    logic        w_req_ready, w_resp_valid, w_resp_err, w_MemWrite, w_MemRead, w_Read_data_Ready;
    logic [63:0] w_resp_rdata, w_Write_data;
    logic [31:0] w_Address, w_perf_ld, w_perf_st, w_perf_split;
    logic [7:0]  w_Write_strb;

    lsu_mc_param #(.DATA_W(32), .MISALIGN_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst), .req_valid(m_req_valid), .req_ready(m_req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata[31:0]), .resp_valid(m_resp_valid), .resp_ready(resp_ready),
        .resp_rdata(m_resp_rdata), .resp_err(m_resp_err), .Address(m_Address), .MemWrite(m_MemWrite),
        .MemRead(m_MemRead), .Write_data(m_Write_data), .Write_strb(m_Write_strb),
        .Mem_Req_Ready(Mem_Req_Ready), .Read_data(Read_data), .Read_data_Valid(Read_data_Valid),
        .Read_data_Ready(m_Read_data_Ready), .perf_ld_cycles(m_perf_ld), .perf_st_cycles(m_perf_st),
        .perf_split(m_perf_split)
    );

    lsu_mc_param #(.DATA_W(32), .MISALIGN_EN(1'b0)) u_dut_nm (
        .clk(clk), .rst(rst), .req_valid(nm_req_valid), .req_ready(nm_req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata[31:0]), .resp_valid(nm_resp_valid), .resp_ready(resp_ready),
        .resp_rdata(nm_resp_rdata), .resp_err(nm_resp_err), .Address(nm_Address),
        .MemWrite(nm_MemWrite), .MemRead(nm_MemRead), .Write_data(nm_Write_data),
        .Write_strb(nm_Write_strb), .Mem_Req_Ready(Mem_Req_Ready), .Read_data(Read_data),
        .Read_data_Valid(Read_data_Valid), .Read_data_Ready(nm_Read_data_Ready),
        .perf_ld_cycles(nm_perf_ld), .perf_st_cycles(nm_perf_st), .perf_split(nm_perf_split)
    );

    lsu_mc_param #(.DATA_W(64), .MISALIGN_EN(1'b1)) u_dut_64 (
        .clk(clk), .rst(rst), .req_valid(w_req_valid), .req_ready(w_req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(w_resp_valid), .resp_ready(resp_ready), .resp_rdata(w_resp_rdata),
        .resp_err(w_resp_err), .Address(w_Address), .MemWrite(w_MemWrite), .MemRead(w_MemRead),
        .Write_data(w_Write_data), .Write_strb(w_Write_strb), .Mem_Req_Ready(Mem_Req_Ready),
        .Read_data({32'h0, Read_data}), .Read_data_Valid(1'b0), .Read_data_Ready(w_Read_data_Ready),
        .perf_ld_cycles(w_perf_ld), .perf_st_cycles(w_perf_st), .perf_split(w_perf_split)
    );

    // Word-addressed memory plus logs of every accepted beat.
    logic [31:0] mem [logic [31:0]];
    logic [31:0] rd_log [32];
    logic [31:0] wr_addr_log [32];
    logic [7:0]  wr_strb_log [32];
    logic [63:0] wr_data_log [32];
    logic [31:0] cur_rd;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          nm_rd_seen = 0;

    always @(negedge clk) begin
        if (m_MemRead && Mem_Req_Ready && rd_cnt < 32) begin
            rd_log[rd_cnt] = m_Address;
            rd_cnt++;
            cur_rd = m_Address;
        end
        if (nm_MemRead) begin
            nm_rd_seen++;
            if (Mem_Req_Ready) cur_rd = nm_Address;
        end
        if (m_MemWrite && Mem_Req_Ready && wr_cnt < 32) begin
            wr_addr_log[wr_cnt] = m_Address;
            wr_strb_log[wr_cnt] = {4'h0, m_Write_strb};
            wr_data_log[wr_cnt] = {32'h0, m_Write_data};
            wr_cnt++;
        end
        if (w_MemWrite && Mem_Req_Ready && wr_cnt < 32) begin
            wr_addr_log[wr_cnt] = w_Address;
            wr_strb_log[wr_cnt] = w_Write_strb;
            wr_data_log[wr_cnt] = w_Write_data;
            wr_cnt++;
        end
        if ((m_Read_data_Ready || nm_Read_data_Ready) && rv_en) begin
            Read_data_Valid = 1'b1;
            Read_data       = mem.exists(cur_rd) ? mem[cur_rd] : 32'h0;
        end else begin
            Read_data_Valid = 1'b0;
            Read_data       = 32'h0;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // sel: 0 = split-capable 32-bit, 1 = reject-misaligned 32-bit, 2 = 64-bit.
    task automatic run_req(input int sel, input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [63:0] wdata,
                           output logic [63:0] rdata, output logic err, output int lat);
        logic got;
        @(negedge clk);
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        m_req_valid  = (sel == 0);
        nm_req_valid = (sel == 1);
        w_req_valid  = (sel == 2);
        @(posedge clk);
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            m_req_valid  = 1'b0;
            nm_req_valid = 1'b0;
            w_req_valid  = 1'b0;
            lat++;
            got = (sel == 0) ? m_resp_valid : (sel == 1) ? nm_resp_valid : w_resp_valid;
        end
        check_eq("resp_timeout", {63'h0, got}, 64'h1);
        // Hold one cycle with resp_ready low; response must stay put.
        @(negedge clk);
        got   = (sel == 0) ? m_resp_valid : (sel == 1) ? nm_resp_valid : w_resp_valid;
        rdata = (sel == 0) ? {32'h0, m_resp_rdata} : (sel == 1) ? {32'h0, nm_resp_rdata} : w_resp_rdata;
        err   = (sel == 0) ? m_resp_err : (sel == 1) ? nm_resp_err : w_resp_err;
        check_eq("resp_hold", {63'h0, got}, 64'h1);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    logic [63:0] rd;
    logic        er;
    int          lat, wb, rb;
    logic        seen;

    initial begin
        rst = 1'b1;
        req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 64'h0;
        m_req_valid = 1'b0; nm_req_valid = 1'b0; w_req_valid = 1'b0;
        resp_ready = 1'b0; Mem_Req_Ready = 1'b1; rv_en = 1'b1;
        Read_data_Valid = 1'b0; Read_data = 32'h0;
        repeat (2) @(negedge clk);
        check_eq("rst_req_ready", {63'h0, m_req_ready}, 64'h1);
        check_eq("rst_resp_valid", {63'h0, m_resp_valid}, 64'h0);
        check_eq("rst_mem", {32'h0, m_Address, m_MemRead, m_MemWrite, m_Read_data_Ready}, 64'h0);
        check_eq("rst_perf", {m_perf_ld, m_perf_st | m_perf_split}, 64'h0);
        rst = 1'b0;

        // SW aligned
        wb = wr_cnt;
        run_req(0, 1'b1, 2'd2, 1'b0, 32'h100, 64'hDEADBEEF, rd, er, lat);
        check_eq("sw_beats", 64'(wr_cnt - wb), 64'd1);
        check_eq("sw_addr", {32'h0, wr_addr_log[wb]}, 64'h100);
        check_eq("sw_strb", {56'h0, wr_strb_log[wb]}, 64'hF);
        check_eq("sw_data", wr_data_log[wb], 64'hDEADBEEF);
        check_eq("sw_err_rdata", {er, rd[62:0]}, 64'h0);
        check_eq("sw_latency", 64'(lat), 64'd2);

        // SB to top lane
        wb = wr_cnt;
        run_req(0, 1'b1, 2'd0, 1'b0, 32'h103, 64'hA5, rd, er, lat);
        check_eq("sb_addr", {32'h0, wr_addr_log[wb]}, 64'h100);
        check_eq("sb_strb", {56'h0, wr_strb_log[wb]}, 64'h8);
        check_eq("sb_data", wr_data_log[wb], 64'hA500_0000);

        // Halfword / byte loads with sign handling
        mem[32'h100] = 32'h8001_1234;
        run_req(0, 1'b0, 2'd1, 1'b0, 32'h102, 64'h0, rd, er, lat);
        check_eq("lh_rdata", rd, 64'hFFFF_8001);
        check_eq("lh_latency", 64'(lat), 64'd3);
        run_req(0, 1'b0, 2'd1, 1'b1, 32'h102, 64'h0, rd, er, lat);
        check_eq("lhu_rdata", rd, 64'h0000_8001);
        run_req(0, 1'b0, 2'd0, 1'b0, 32'h103, 64'h0, rd, er, lat);
        check_eq("lb_rdata", rd, 64'hFFFF_FF80);

        // Split LW across 0x100
        mem[32'h0FC] = 32'h2211_0000;
        mem[32'h100] = 32'h0000_4433;
        rb = rd_cnt;
        run_req(0, 1'b0, 2'd2, 1'b0, 32'h0FE, 64'h0, rd, er, lat);
        check_eq("lw_split_rdata", rd, 64'h4433_2211);
        check_eq("lw_split_err", {63'h0, er}, 64'h0);
        check_eq("lw_split_beats", 64'(rd_cnt - rb), 64'd2);
        check_eq("lw_split_addrs", {rd_log[rb], rd_log[rb + 1]}, {32'h0FC, 32'h100});
        check_eq("lw_split_latency", 64'(lat), 64'd5);
        check_eq("perf_split_1", {32'h0, m_perf_split}, 64'd1);
        check_eq("perf_ld_10", {32'h0, m_perf_ld}, 64'd10);
        check_eq("perf_st_2", {32'h0, m_perf_st}, 64'd2);

        // Split SW across 0x100
        wb = wr_cnt;
        run_req(0, 1'b1, 2'd2, 1'b0, 32'h0FE, 64'hAABBCCDD, rd, er, lat);
        check_eq("sw_split_beats", 64'(wr_cnt - wb), 64'd2);
        check_eq("sw_split_b0", {wr_addr_log[wb], 24'h0, wr_strb_log[wb]}, {32'h0FC, 32'hC});
        check_eq("sw_split_d0", wr_data_log[wb], 64'hCCDD_0000);
        check_eq("sw_split_b1", {wr_addr_log[wb + 1], 24'h0, wr_strb_log[wb + 1]}, {32'h100, 32'h3});
        check_eq("sw_split_d1", wr_data_log[wb + 1], 64'h0000_AABB);
        check_eq("perf_split_2", {32'h0, m_perf_split}, 64'd2);
        check_eq("perf_st_4", {32'h0, m_perf_st}, 64'd4);

        // Size D is illegal on a 32-bit bus
        wb = wr_cnt;
        run_req(0, 1'b1, 2'd3, 1'b0, 32'h100, 64'h1, rd, er, lat);
        check_eq("sd32_err", {63'h0, er}, 64'h1);
        check_eq("sd32_no_write", 64'(wr_cnt - wb), 64'd0);
        check_eq("sd32_latency", 64'(lat), 64'd1);

        // Misaligned LW rejected when splitting is disabled
        run_req(1, 1'b0, 2'd2, 1'b0, 32'h0FE, 64'h0, rd, er, lat);
        check_eq("nm_err", {63'h0, er}, 64'h1);
        check_eq("nm_rdata", rd, 64'h0);
        check_eq("nm_no_read", 64'(nm_rd_seen), 64'd0);
        run_req(1, 1'b0, 2'd2, 1'b0, 32'h100, 64'h0, rd, er, lat);
        check_eq("nm_aligned_rdata", {er, rd[62:0]}, 64'h4433);

        // 64-bit SD
        wb = wr_cnt;
        run_req(2, 1'b1, 2'd3, 1'b0, 32'h8, 64'h1122_3344_5566_7788, rd, er, lat);
        check_eq("sd64_err", {63'h0, er}, 64'h0);
        check_eq("sd64_addr_strb", {wr_addr_log[wb], 24'h0, wr_strb_log[wb]}, {32'h8, 32'hFF});
        check_eq("sd64_data", wr_data_log[wb], 64'h1122_3344_5566_7788);

        // Reset while stalled in RW0 with resp_ready low
        rv_en = 1'b0;
        @(negedge clk);
        req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h100;
        m_req_valid = 1'b1;
        @(negedge clk);
        m_req_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = m_Read_data_Ready;
        end
        check_eq("rw0_reached", {63'h0, seen}, 64'h1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("mid_rst_idle", {59'h0, m_req_ready, m_MemRead, m_resp_valid, m_Read_data_Ready,
                                  m_MemWrite}, 64'h10);
        check_eq("mid_rst_perf", {m_perf_ld, m_perf_st | m_perf_split}, 64'h0);
        rst = 1'b0;
        rv_en = 1'b1;

        run_req(0, 1'b0, 2'd2, 1'b0, 32'h100, 64'h0, rd, er, lat);
        check_eq("post_rst_lw", {er, rd[62:0]}, 64'h4433);
        check_eq("post_rst_perf_ld", {32'h0, m_perf_ld}, 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
